// File: rtl/ctmm_load_issue.sv
// CLOOMC LOAD issue stage: request FIFO, engine handshake FSM, tagged completion.
// Optional watchdog on in-flight loads is built when CTMM_LOAD_WDOG_EN is defined.

package ctmm_load_pkg;

    typedef logic [3:0] fault_type_t;

endpackage

module ctmm_load_issue
    import ctmm_load_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TAG_W       = 4,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_cr_src,
    input  logic [3:0]       req_cr_dst,
    input  logic [7:0]       req_index,
    input  logic [TAG_W-1:0] req_tag,

    output logic             load_start,
    output logic [3:0]       load_cr_src,
    output logic [3:0]       load_cr_dst,
    output logic [7:0]       load_index,
    input  logic             load_busy,
    input  logic             load_complete,
    input  logic             load_fault,
    input  fault_type_t      load_fault_type,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_fault,
    output fault_type_t      rsp_fault_type,
    output logic             rsp_illegal,
    output logic             rsp_timeout,

    output logic             issue_idle
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [3:0] CR_NAMESPACE = 4'hF;

    typedef struct packed {
        logic [3:0]       src;
        logic [3:0]       dst;
        logic [7:0]       idx;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_RESP,
        S_DRAIN
    } state_t;

    // ---------------------------------------------------------------
    // Request FIFO
    // ---------------------------------------------------------------
    req_t          r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    req_t          w_head;
    req_t          w_in;

    state_t        r_state;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign req_ready = !w_full;

    assign w_push = req_valid && !w_full;
    assign w_pop  = (r_state == S_IDLE) && !w_empty;

    assign w_head = r_mem[r_rd_ptr[AW-1:0]];

    assign w_in.src = req_cr_src;
    assign w_in.dst = req_cr_dst;
    assign w_in.idx = req_index;
    assign w_in.tag = req_tag;

    // Pointer update; the extra MSB separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage write on push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_in;
        end
    end

    // ---------------------------------------------------------------
    // Watchdog
    // ---------------------------------------------------------------
    logic w_wdog_exp;

`ifdef CTMM_LOAD_WDOG_EN
    localparam int CW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

    logic [CW-1:0] r_wdog_cnt;

    assign w_wdog_exp = (r_wdog_cnt == CW'(WDOG_CYCLES - 1));

    // Cleared as the FSM enters WAIT_ACK, counts while a load is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_wdog_cnt <= '0;
        end else if ((r_state == S_WAIT_ACK) ||
                     (r_state == S_WAIT_DONE)) begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
        end
    end
`else
    logic w_unused_wdog;

    assign w_unused_wdog = ^WDOG_CYCLES;
    assign w_wdog_exp    = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Issue FSM with registered outputs
    // ---------------------------------------------------------------
    logic             r_load_start;
    logic [3:0]       r_load_src;
    logic [3:0]       r_load_dst;
    logic [7:0]       r_load_idx;
    logic [TAG_W-1:0] r_hold_tag;
    logic             r_wdog_fired;

    logic             r_rsp_valid;
    logic [TAG_W-1:0] r_rsp_tag;
    logic             r_rsp_fault;
    fault_type_t      r_rsp_fault_type;
    logic             r_rsp_illegal;
    logic             r_rsp_timeout;

    // Sequences one request at a time through the engine handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_load_start     <= 1'b0;
            r_load_src       <= '0;
            r_load_dst       <= '0;
            r_load_idx       <= '0;
            r_hold_tag       <= '0;
            r_wdog_fired     <= 1'b0;
            r_rsp_valid      <= 1'b0;
            r_rsp_tag        <= '0;
            r_rsp_fault      <= 1'b0;
            r_rsp_fault_type <= '0;
            r_rsp_illegal    <= 1'b0;
            r_rsp_timeout    <= 1'b0;
        end else begin
            r_load_start <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_hold_tag   <= w_head.tag;
                        r_wdog_fired <= 1'b0;
                        if (w_head.dst == CR_NAMESPACE) begin
                            r_rsp_valid      <= 1'b1;
                            r_rsp_tag        <= w_head.tag;
                            r_rsp_fault      <= 1'b0;
                            r_rsp_fault_type <= '0;
                            r_rsp_illegal    <= 1'b1;
                            r_rsp_timeout    <= 1'b0;
                            r_state          <= S_RESP;
                        end else begin
                            r_load_src   <= w_head.src;
                            r_load_dst   <= w_head.dst;
                            r_load_idx   <= w_head.idx;
                            r_load_start <= 1'b1;
                            r_state      <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (w_wdog_exp) begin
                        r_rsp_valid      <= 1'b1;
                        r_rsp_tag        <= r_hold_tag;
                        r_rsp_fault      <= 1'b1;
                        r_rsp_fault_type <= '0;
                        r_rsp_illegal    <= 1'b0;
                        r_rsp_timeout    <= 1'b1;
                        r_wdog_fired     <= 1'b1;
                        r_state          <= S_RESP;
                    end else if (load_busy) begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (load_fault) begin
                        r_rsp_valid      <= 1'b1;
                        r_rsp_tag        <= r_hold_tag;
                        r_rsp_fault      <= 1'b1;
                        r_rsp_fault_type <= load_fault_type;
                        r_rsp_illegal    <= 1'b0;
                        r_rsp_timeout    <= 1'b0;
                        r_state          <= S_RESP;
                    end else if (load_complete) begin
                        r_rsp_valid      <= 1'b1;
                        r_rsp_tag        <= r_hold_tag;
                        r_rsp_fault      <= 1'b0;
                        r_rsp_fault_type <= '0;
                        r_rsp_illegal    <= 1'b0;
                        r_rsp_timeout    <= 1'b0;
                        r_state          <= S_RESP;
                    end else if (w_wdog_exp) begin
                        r_rsp_valid      <= 1'b1;
                        r_rsp_tag        <= r_hold_tag;
                        r_rsp_fault      <= 1'b1;
                        r_rsp_fault_type <= '0;
                        r_rsp_illegal    <= 1'b0;
                        r_rsp_timeout    <= 1'b1;
                        r_wdog_fired     <= 1'b1;
                        r_state          <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= r_wdog_fired ? S_DRAIN : S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (!load_busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Idle is reported from the first clock after reset so that every
    // output other than req_ready reads zero while reset is held.
    logic r_live;

    // Marks the block as out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    assign issue_idle = r_live && w_empty && (r_state == S_IDLE);

    assign load_start     = r_load_start;
    assign load_cr_src    = r_load_src;
    assign load_cr_dst    = r_load_dst;
    assign load_index     = r_load_idx;

    assign rsp_valid      = r_rsp_valid;
    assign rsp_tag        = r_rsp_tag;
    assign rsp_fault      = r_rsp_fault;
    assign rsp_fault_type = r_rsp_fault_type;
    assign rsp_illegal    = r_rsp_illegal;
    assign rsp_timeout    = r_rsp_timeout;

endmodule

// File: tb/tb_ctmm_load_issue.sv
// Directed bench for ctmm_load_issue: issue, illegal CRd, FIFO fill/order,
// fault priority, watchdog (when CTMM_LOAD_WDOG_EN) and mid-flight reset.

module tb_ctmm_load_issue;
    import ctmm_load_pkg::*;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [3:0]       req_cr_src = '0;
    logic [3:0]       req_cr_dst = '0;
    logic [7:0]       req_index = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             load_start;
    logic [3:0]       load_cr_src;
    logic [3:0]       load_cr_dst;
    logic [7:0]       load_index;
    logic             load_busy = 1'b0;
    logic             load_complete = 1'b0;
    logic             load_fault = 1'b0;
    fault_type_t      load_fault_type = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_fault;
    fault_type_t      rsp_fault_type;
    logic             rsp_illegal;
    logic             rsp_timeout;
    logic             issue_idle;

    int n_chk  = 0;
    int n_pass = 0;
    int start_cnt = 0;

    ctmm_load_issue #(
        .FIFO_DEPTH  (4),
        .TAG_W       (TAG_W),
        .WDOG_CYCLES (16)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_cr_src      (req_cr_src),
        .req_cr_dst      (req_cr_dst),
        .req_index       (req_index),
        .req_tag         (req_tag),
        .load_start      (load_start),
        .load_cr_src     (load_cr_src),
        .load_cr_dst     (load_cr_dst),
        .load_index      (load_index),
        .load_busy       (load_busy),
        .load_complete   (load_complete),
        .load_fault      (load_fault),
        .load_fault_type (load_fault_type),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_tag         (rsp_tag),
        .rsp_fault       (rsp_fault),
        .rsp_fault_type  (rsp_fault_type),
        .rsp_illegal     (rsp_illegal),
        .rsp_timeout     (rsp_timeout),
        .issue_idle      (issue_idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_start) begin
            start_cnt <= start_cnt + 1;
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [3:0] s, input logic [3:0] d,
                        input logic [7:0] x, input logic [3:0] t);
        req_valid  = 1'b1;
        req_cr_src = s;
        req_cr_dst = d;
        req_index  = x;
        req_tag    = t;
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int i = 0;
        while (!load_start && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_start"}, 32'(load_start), 32'd1);
    endtask

    task automatic wait_rsp(input string tag);
        int i = 0;
        while (!rsp_valid && i < 60) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_rsp"}, 32'(rsp_valid), 32'd1);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic serve_ok();
        load_busy = 1'b1;
        cyc(2);
        load_busy     = 1'b0;
        load_complete = 1'b1;
        cyc(1);
        load_complete = 1'b0;
    endtask

    initial begin
        int s0;
        int seen;

        // Reset values
        cyc(2);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rspv",  32'(rsp_valid), 32'd0);
        chk("rst_start", 32'(load_start), 32'd0);
        chk("rst_idle",  32'(issue_idle), 32'd0);
        rst_n = 1'b1;
        cyc(1);
        chk("idle_after_rst", 32'(issue_idle), 32'd1);

        // 1: normal load
        push(4'd3, 4'd5, 8'h12, 4'd1);
        wait_start("t1");
        chk("t1_src", 32'(load_cr_src), 32'd3);
        chk("t1_dst", 32'(load_cr_dst), 32'd5);
        chk("t1_idx", 32'(load_index), 32'h12);
        load_busy = 1'b1;
        cyc(3);
        load_busy     = 1'b0;
        load_complete = 1'b1;
        cyc(1);
        load_complete = 1'b0;
        wait_rsp("t1");
        chk("t1_tag",   32'(rsp_tag), 32'd1);
        chk("t1_fault", 32'(rsp_fault), 32'd0);
        chk("t1_ill",   32'(rsp_illegal), 32'd0);
        chk("t1_to",    32'(rsp_timeout), 32'd0);
        take_rsp();
        chk("t1_starts", 32'(start_cnt), 32'd1);
        chk("t1_rspv_low", 32'(rsp_valid), 32'd0);

        // 2: CRd == 15 rejected without issue
        s0 = start_cnt;
        push(4'd1, 4'd15, 8'h00, 4'd2);
        wait_rsp("t2");
        chk("t2_ill",    32'(rsp_illegal), 32'd1);
        chk("t2_tag",    32'(rsp_tag), 32'd2);
        chk("t2_fault",  32'(rsp_fault), 32'd0);
        take_rsp();
        chk("t2_nostart", 32'(start_cnt - s0), 32'd0);

        // 4: fault and complete together, fault wins
        push(4'd2, 4'd4, 8'h33, 4'd6);
        wait_start("t4");
        load_busy = 1'b1;
        cyc(2);
        load_busy       = 1'b0;
        load_complete   = 1'b1;
        load_fault      = 1'b1;
        load_fault_type = 4'hB;
        cyc(1);
        load_complete   = 1'b0;
        load_fault      = 1'b0;
        load_fault_type = 4'h0;
        wait_rsp("t4");
        chk("t4_fault", 32'(rsp_fault), 32'd1);
        chk("t4_ftype", 32'(rsp_fault_type), 32'hB);
        chk("t4_tag",   32'(rsp_tag), 32'd6);
        take_rsp();

        // 3: fill the FIFO behind a held response, then drain in order
        push(4'd0, 4'd15, 8'h00, 4'd9);
        wait_rsp("t3_blk");
        for (int k = 0; k < 4; k++) begin
            push(4'(k), 4'(k + 1), 8'(8'h40 + k), 4'(k));
            if (k == 2) begin
                chk("t3_ready3", 32'(req_ready), 32'd1);
            end
        end
        chk("t3_full", 32'(req_ready), 32'd0);
        push(4'd7, 4'd7, 8'h77, 4'd7);
        chk("t3_still_full", 32'(req_ready), 32'd0);
        chk("t3_blk_tag", 32'(rsp_tag), 32'd9);
        take_rsp();
        for (int k = 0; k < 4; k++) begin
            wait_start("t3");
            chk("t3_idx", 32'(load_index), 32'(8'h40 + k));
            serve_ok();
            wait_rsp("t3");
            chk("t3_tag", 32'(rsp_tag), 32'(k));
            take_rsp();
        end
        chk("t3_empty", 32'(issue_idle), 32'd1);

`ifdef CTMM_LOAD_WDOG_EN
        // 5: watchdog expiry and drain
        push(4'd1, 4'd2, 8'h55, 4'd3);
        wait_start("t5");
        load_busy = 1'b1;
        seen = 0;
        while (!rsp_valid && seen < 100) begin
            @(negedge clk);
            seen++;
        end
        chk("t5_latency", 32'(seen), 32'd17);
        chk("t5_to",    32'(rsp_timeout), 32'd1);
        chk("t5_fault", 32'(rsp_fault), 32'd1);
        chk("t5_ftype", 32'(rsp_fault_type), 32'd0);
        chk("t5_tag",   32'(rsp_tag), 32'd3);
        take_rsp();
        s0 = start_cnt;
        push(4'd4, 4'd2, 8'h66, 4'd5);
        cyc(5);
        chk("t5_drain_hold", 32'(start_cnt - s0), 32'd0);
        load_busy = 1'b0;
        wait_start("t5b");
        serve_ok();
        wait_rsp("t5b");
        chk("t5b_tag", 32'(rsp_tag), 32'd5);
        chk("t5b_to",  32'(rsp_timeout), 32'd0);
        take_rsp();
`endif

        // 6: reset in WAIT_DONE with two queued
        push(4'd1, 4'd2, 8'h03, 4'hA);
        wait_start("t6");
        load_busy = 1'b1;
        push(4'd2, 4'd3, 8'h04, 4'hB);
        push(4'd3, 4'd4, 8'h05, 4'hC);
        rst_n = 1'b0;
        #1;
        chk("t6_ready", 32'(req_ready), 32'd1);
        chk("t6_rspv",  32'(rsp_valid), 32'd0);
        chk("t6_start", 32'(load_start), 32'd0);
        chk("t6_src",   32'(load_cr_src), 32'd0);
        chk("t6_dst",   32'(load_cr_dst), 32'd0);
        chk("t6_idx",   32'(load_index), 32'd0);
        chk("t6_idle",  32'(issue_idle), 32'd0);
        load_busy = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        s0 = start_cnt;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen++;
            end
        end
        chk("t6_no_rsp",   32'(seen), 32'd0);
        chk("t6_no_start", 32'(start_cnt - s0), 32'd0);
        chk("t6_idle_after", 32'(issue_idle), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
